// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle sequencer and the memory/datapath side.
// The sequencer takes the master side; memory and datapath take the slave side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode_Instr;
  logic             zero, negative, overflow, carry_out;
  logic             mem_ack;
  logic             mem_req, IorD, IRWrite, Reg2Loc;
  logic [1:0]       ALUSrc, MemtoReg;
  logic [2:0]       ALUOp_bits;
  logic             MemRead, MemWrite, RegWrite;
  logic             Branch, UncondBr, PCWrite;
  logic [3:0]       flags;
  logic             trap, trap_cause;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode_Instr, zero, negative, overflow, carry_out, mem_ack,
    output mem_req, IorD, IRWrite, Reg2Loc, ALUSrc, MemtoReg, ALUOp_bits,
           MemRead, MemWrite, RegWrite, Branch, UncondBr, PCWrite,
           flags, trap, trap_cause, retired
  );
  modport slave (
    output opcode_Instr, zero, negative, overflow, carry_out, mem_ack,
    input  mem_req, IorD, IRWrite, Reg2Loc, ALUSrc, MemtoReg, ALUOp_bits,
           MemRead, MemWrite, RegWrite, Branch, UncondBr, PCWrite,
           flags, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// LEGv8-subset multi-cycle sequencer: FETCH/DECODE/EXEC/MULW/MEM/WB with mem
// handshake timeout, NZVC flag register, sticky trap and retired counter.
module multicycle_control #(
  parameter int MUL_LATENCY = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam int MW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MULW, MEM, WB, TRAP} state_e;
  typedef enum logic [3:0] {
    I_NONE, I_B, I_BLT, I_CBZ, I_ADDI, I_ADDS, I_SUBS,
    I_LDUR, I_STUR, I_LSL, I_LSR, I_MUL
  } instr_e;

  typedef struct packed {
    logic       mem_req, IorD, IRWrite, Reg2Loc;
    logic [1:0] ALUSrc, MemtoReg;
    logic [2:0] ALUOp;
    logic       MemRead, MemWrite, RegWrite, Branch, UncondBr, PCWrite;
  } ctl_t;

  state_e           state_q;
  logic [10:0]      op_q;
  logic [3:0]       flags_q;
  logic             trap_q, cause_q;
  logic [CNT_W-1:0] retired_q;
  logic [TW-1:0]    tmo_q;
  logic [MW-1:0]    mul_q;
  instr_e           cls;
  ctl_t             ctl_c, ctl_o;

  always_comb begin
    cls = I_NONE;
    casez (op_q)
      11'b000101?????: cls = I_B;
      11'b01010100???: cls = I_BLT;
      11'b10110100???: cls = I_CBZ;
      11'b1001000100?: cls = I_ADDI;
      11'b10101011000: cls = I_ADDS;
      11'b11101011000: cls = I_SUBS;
      11'b11111000010: cls = I_LDUR;
      11'b11111000000: cls = I_STUR;
      11'b11010011011: cls = I_LSL;
      11'b11010011010: cls = I_LSR;
      11'b10011011000: cls = I_MUL;
      default:         cls = I_NONE;
    endcase
  end

  always_comb begin
    ctl_c = '0;
    // Operand selects stay put from EXEC through WB so the ALU result is stable.
    if (state_q inside {EXEC, MULW, MEM, WB}) begin
      case (cls)
        I_ADDI:         begin ctl_c.ALUSrc = 2'b10; ctl_c.ALUOp = 3'b010; end
        I_ADDS:         begin ctl_c.Reg2Loc = 1'b1; ctl_c.ALUOp = 3'b010; end
        I_SUBS:         begin ctl_c.Reg2Loc = 1'b1; ctl_c.ALUOp = 3'b011; end
        I_LDUR, I_STUR: begin ctl_c.ALUSrc = 2'b01; ctl_c.ALUOp = 3'b010; end
        I_MUL:          ctl_c.Reg2Loc = 1'b1;
        default:        ;
      endcase
    end
    case (state_q)
      FETCH: begin
        ctl_c.mem_req = 1'b1;
        ctl_c.MemRead = 1'b1;
        ctl_c.IRWrite = bus.mem_ack;
      end
      DECODE: if (cls == I_B) begin
        ctl_c.Branch = 1'b1; ctl_c.UncondBr = 1'b1; ctl_c.PCWrite = 1'b1;
      end
      EXEC: begin
        if (cls == I_CBZ) begin
          ctl_c.Branch = bus.zero; ctl_c.PCWrite = 1'b1;
        end else if (cls == I_BLT) begin
          ctl_c.Branch = flags_q[3] ^ flags_q[0]; ctl_c.PCWrite = 1'b1;
        end
      end
      MEM: begin
        ctl_c.mem_req  = 1'b1;
        ctl_c.IorD     = 1'b1;
        ctl_c.MemRead  = (cls == I_LDUR);
        ctl_c.MemWrite = (cls == I_STUR);
        ctl_c.PCWrite  = (cls == I_STUR) && bus.mem_ack;
      end
      WB: begin
        ctl_c.RegWrite = 1'b1;
        ctl_c.PCWrite  = 1'b1;
        case (cls)
          I_LDUR:        ctl_c.MemtoReg = 2'b01;
          I_LSL, I_LSR:  ctl_c.MemtoReg = 2'b10;
          I_MUL:         ctl_c.MemtoReg = 2'b11;
          default:       ctl_c.MemtoReg = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      flags_q   <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
      retired_q <= '0;
      tmo_q     <= '0;
      mul_q     <= '0;
    end else begin
      tmo_q <= '0;
      if (ctl_c.PCWrite) retired_q <= retired_q + 1'b1;
      case (state_q)
        FETCH, MEM: begin
          if (bus.mem_ack) begin
            if (state_q == FETCH) begin
              op_q    <= bus.opcode_Instr;
              state_q <= DECODE;
            end else begin
              state_q <= (cls == I_LDUR) ? WB : FETCH;
            end
          end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DECODE: begin
          if (cls == I_B) state_q <= FETCH;
          else if (cls == I_NONE) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= 1'b0;
          end else state_q <= EXEC;
        end
        EXEC: begin
          case (cls)
            I_ADDS, I_SUBS: begin
              flags_q <= {bus.negative, bus.zero, bus.carry_out, bus.overflow};
              state_q <= WB;
            end
            I_ADDI, I_LSL, I_LSR: state_q <= WB;
            I_LDUR, I_STUR:       state_q <= MEM;
            I_MUL: begin
              mul_q   <= MW'(MUL_LATENCY - 1);
              state_q <= (MUL_LATENCY == 1) ? WB : MULW;
            end
            default: state_q <= FETCH;
          endcase
        end
        MULW: begin
          // Transition on the last decrement so EXEC+MULW spans MUL_LATENCY cycles.
          mul_q <= mul_q - 1'b1;
          if (mul_q == MW'(1)) state_q <= WB;
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign ctl_o = reset ? '0 : ctl_c;

  assign bus.mem_req    = ctl_o.mem_req;
  assign bus.IorD       = ctl_o.IorD;
  assign bus.IRWrite    = ctl_o.IRWrite;
  assign bus.Reg2Loc    = ctl_o.Reg2Loc;
  assign bus.ALUSrc     = ctl_o.ALUSrc;
  assign bus.MemtoReg   = ctl_o.MemtoReg;
  assign bus.ALUOp_bits = ctl_o.ALUOp;
  assign bus.MemRead    = ctl_o.MemRead;
  assign bus.MemWrite   = ctl_o.MemWrite;
  assign bus.RegWrite   = ctl_o.RegWrite;
  assign bus.Branch     = ctl_o.Branch;
  assign bus.UncondBr   = ctl_o.UncondBr;
  assign bus.PCWrite    = ctl_o.PCWrite;
  assign bus.flags      = reset ? 4'b0 : flags_q;
  assign bus.trap       = reset ? 1'b0 : trap_q;
  assign bus.trap_cause = reset ? 1'b0 : cause_q;
  assign bus.retired    = reset ? '0 : retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-computed control/flag/counter
// values checked with immediate assertions along one linear instruction stream.
module tb_multicycle_control;
  localparam int CNT_W = 32;
  localparam logic [10:0] OP_B    = 11'h0A0;
  localparam logic [10:0] OP_BLT  = 11'h2A0;
  localparam logic [10:0] OP_CBZ  = 11'h5A0;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_MUL  = 11'h4D8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(
    .MUL_LATENCY(4),
    .MEM_TIMEOUT(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // FETCH cycle with zero-wait ack; returns in DECODE with ack low.
  task automatic fetch(input logic [10:0] op);
    bus.opcode_Instr = op;
    bus.mem_ack      = 1'b1;
    settle();
    chk("fetch_irwrite", 64'(bus.IRWrite), 64'd1);
    tick();
    bus.mem_ack = 1'b0;
    settle();
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode_Instr = '0;
    bus.zero = 1'b0; bus.negative = 1'b0; bus.overflow = 1'b0; bus.carry_out = 1'b0;
    bus.mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_pcwrite", 64'(bus.PCWrite), 64'd0);
    chk("rst_retired", 64'(bus.retired), 64'd0);
    chk("rst_flags",   64'(bus.flags),   64'd0);
    chk("rst_trap",    64'(bus.trap),    64'd0);

    reset = 1'b0;
    settle();
    chk("fetch_req",     64'(bus.mem_req), 64'd1);
    chk("fetch_memread", 64'(bus.MemRead), 64'd1);
    chk("fetch_iord",    64'(bus.IorD),    64'd0);
    chk("fetch_noack",   64'(bus.IRWrite), 64'd0);

    // STUR aborted by reset in MEM
    fetch(OP_STUR);
    chk("stur_dec_pcw", 64'(bus.PCWrite), 64'd0);
    tick();
    chk("stur_alusrc", 64'(bus.ALUSrc),     64'd1);
    chk("stur_aluop",  64'(bus.ALUOp_bits), 64'd2);
    tick();
    chk("stur_memwr",  64'(bus.MemWrite), 64'd1);
    chk("stur_iord",   64'(bus.IorD),     64'd1);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    settle();
    chk("rstcyc_memwr", 64'(bus.MemWrite), 64'd0);
    chk("rstcyc_pcw",   64'(bus.PCWrite),  64'd0);
    tick();
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    settle();
    chk("postrst_fetch", 64'(bus.MemRead),  64'd1);
    chk("postrst_memwr", 64'(bus.MemWrite), 64'd0);
    chk("postrst_ret",   64'(bus.retired),  64'd0);
    chk("postrst_flags", 64'(bus.flags),    64'd0);

    // ADDS sets {N,Z,C,V}=0110, then B.LT not taken
    fetch(OP_ADDS);
    tick();
    bus.negative = 1'b0; bus.zero = 1'b1; bus.carry_out = 1'b1; bus.overflow = 1'b0;
    settle();
    chk("adds_aluop",   64'(bus.ALUOp_bits), 64'd2);
    chk("adds_reg2loc", 64'(bus.Reg2Loc),    64'd1);
    tick();
    chk("adds_flags",    64'(bus.flags),    64'h6);
    chk("adds_regwrite", 64'(bus.RegWrite), 64'd1);
    chk("adds_pcw",      64'(bus.PCWrite),  64'd1);
    chk("adds_m2r",      64'(bus.MemtoReg), 64'd0);
    bus.negative = 1'b1; bus.zero = 1'b0; bus.carry_out = 1'b0;
    tick();
    chk("adds_retired", 64'(bus.retired), 64'd1);
    fetch(OP_BLT);
    tick();
    chk("blt_nt_branch", 64'(bus.Branch),   64'd0);
    chk("blt_nt_uncond", 64'(bus.UncondBr), 64'd0);
    chk("blt_nt_pcw",    64'(bus.PCWrite),  64'd1);
    tick();
    chk("blt_nt_ret",    64'(bus.retired), 64'd2);
    chk("blt_nt_flags",  64'(bus.flags),   64'h6);

    // SUBS with N=1,V=0 then B.LT taken from registered flags
    fetch(OP_SUBS);
    tick();
    bus.negative = 1'b1; bus.zero = 1'b0; bus.carry_out = 1'b0; bus.overflow = 1'b0;
    settle();
    chk("subs_aluop", 64'(bus.ALUOp_bits), 64'd3);
    tick();
    chk("subs_flags", 64'(bus.flags), 64'h8);
    bus.negative = 1'b0;
    tick();
    fetch(OP_BLT);
    tick();
    chk("blt_t_branch", 64'(bus.Branch),   64'd1);
    chk("blt_t_uncond", 64'(bus.UncondBr), 64'd0);
    chk("blt_t_pcw",    64'(bus.PCWrite),  64'd1);
    tick();
    chk("blt_t_ret", 64'(bus.retired), 64'd4);

    // MUL: FETCH=1, DECODE=2, EXEC=3, MULW=4..6, WB=7
    fetch(OP_MUL);
    tick();
    for (int cyc = 3; cyc <= 6; cyc++) begin
      chk("mul_wait_rw", 64'(bus.RegWrite), 64'd0);
      tick();
    end
    chk("mul_wb_rw",  64'(bus.RegWrite), 64'd1);
    chk("mul_wb_m2r", 64'(bus.MemtoReg), 64'd3);
    chk("mul_wb_pcw", 64'(bus.PCWrite),  64'd1);
    tick();
    chk("mul_ret", 64'(bus.retired), 64'd5);

    // B resolves in DECODE
    fetch(OP_B);
    chk("b_branch", 64'(bus.Branch),   64'd1);
    chk("b_uncond", 64'(bus.UncondBr), 64'd1);
    chk("b_pcw",    64'(bus.PCWrite),  64'd1);
    tick();
    chk("b_ret", 64'(bus.retired), 64'd6);

    // CBZ follows live zero
    fetch(OP_CBZ);
    tick();
    bus.zero = 1'b1;
    settle();
    chk("cbz_branch1", 64'(bus.Branch),  64'd1);
    chk("cbz_pcw",     64'(bus.PCWrite), 64'd1);
    chk("cbz_reg2loc", 64'(bus.Reg2Loc), 64'd0);
    bus.zero = 1'b0;
    settle();
    chk("cbz_branch0", 64'(bus.Branch), 64'd0);
    tick();
    chk("cbz_ret", 64'(bus.retired), 64'd7);

    // LDUR: spurious ack in DECODE ignored; ack on 16th request cycle wins
    fetch(OP_LDUR);
    bus.mem_ack = 1'b1;
    settle();
    chk("spur_req", 64'(bus.mem_req), 64'd0);
    tick();
    bus.mem_ack = 1'b0;
    settle();
    chk("ldur_exec_req", 64'(bus.mem_req), 64'd0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk("ldur_wait_rd",   64'(bus.MemRead), 64'd1);
      chk("ldur_wait_trap", 64'(bus.trap),    64'd0);
      tick();
    end
    bus.mem_ack = 1'b1;
    settle();
    chk("ldur_ack16_req", 64'(bus.mem_req), 64'd1);
    tick();
    bus.mem_ack = 1'b0;
    settle();
    chk("ldur_ack16_trap", 64'(bus.trap),     64'd0);
    chk("ldur_wb_rw",      64'(bus.RegWrite), 64'd1);
    chk("ldur_wb_m2r",     64'(bus.MemtoReg), 64'd1);
    tick();
    chk("ldur_ret", 64'(bus.retired), 64'd8);

    // LDUR with ack withheld: bus timeout after 16 request cycles
    fetch(OP_LDUR);
    tick();
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk("tmo_wait_trap", 64'(bus.trap), 64'd0);
      tick();
    end
    chk("tmo_trap",  64'(bus.trap),       64'd1);
    chk("tmo_cause", 64'(bus.trap_cause), 64'd1);
    chk("tmo_req",   64'(bus.mem_req),    64'd0);
    chk("tmo_ret",   64'(bus.retired),    64'd8);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rst2_trap", 64'(bus.trap),    64'd0);
    chk("rst2_ret",  64'(bus.retired), 64'd0);

    // Illegal opcode traps and never retires
    fetch(11'h000);
    chk("ill_dec_pcw", 64'(bus.PCWrite), 64'd0);
    tick();
    chk("ill_trap",  64'(bus.trap),       64'd1);
    chk("ill_cause", 64'(bus.trap_cause), 64'd0);
    for (int k = 0; k < 20; k++) begin
      bus.mem_ack = k[0];
      settle();
      chk("ill_pcw", 64'(bus.PCWrite), 64'd0);
      chk("ill_req", 64'(bus.mem_req), 64'd0);
      tick();
    end
    chk("ill_ret", 64'(bus.retired), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
